uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
// Parametrised UART receiver, successor to the fixed 8-bit receive FSM. Frame format, oversampling
// and runtime baud divisor are configurable. Start and data bits are sampled by 3-sample majority vote.
// Parity, framing and overrun errors are reported. Received words go to the core over a valid/ready port.
// Sits between the board RX pin and the memory-mapped UART register block of the pipeline core.
// PARAMETERS
// DATA_BITS   8   data bits per frame, legal 5..9
// PARITY_EN   1   1 = one parity bit follows data; 0 = no parity bit
// PARITY_ODD  0   1 = odd parity, 0 = even; ignored when PARITY_EN=0
// STOP_BITS   1   stop bits checked, legal 1..2
// OVERSAMPLE  16  ticks per bit, legal 8 or 16
// DIV_W       16  width of baud_div
// PORTS
// clk         in   1          system clock
// rst         in   1          asynchronous, active-low reset
// baud_div    in   DIV_W      clocks per oversample tick minus 1; sampled only in IDLE
// rx          in   1          serial input, asynchronous, idle high
// rx_data     out  DATA_BITS  received word, LSB = first bit on the line
// rx_valid    out  1          rx_data and error flags valid
// rx_ready    in   1          consumer accepts word when rx_valid & rx_ready
// parity_err  out  1          parity mismatch for the word in rx_data
// frame_err   out  1          a stop bit was sampled low for the word in rx_data
// overrun     out  1          1-cycle pulse: frame completed while rx_valid & ~rx_ready; frame dropped
// busy        out  1          high from start-edge detect until return to IDLE
// BEHAVIOUR
// - Reset (rst=0, async): FSM=IDLE, outputs all 0, rx_data=0, synchroniser set to 1, counters 0.
// - rx passes a 2-FF synchroniser (rxs); all decisions use rxs. Pin to rxs latency is 2 clk.
// - Tick gen: counter reloads baud_div and emits a 1-clk tick on reaching 0. Free-runs outside IDLE.
//   Restarts from baud_div on start-edge detect.
// - Bit sampling: tick counter 0..OVERSAMPLE-1 per bit.
//   Samples are taken at ticks OVERSAMPLE/2-1, /2 and /2+1; the bit value is the 2-of-3 majority.
// - FSM states: IDLE, START, DATA, PARITY, STOP, DELIVER, BREAK.
//   IDLE -> START on rxs 1->0 edge; busy=1.
//   START: at end of bit, majority=1 -> IDLE (glitch rejected, nothing reported); else -> DATA.
//   DATA: shift majority in LSB-first; after DATA_BITS bits -> PARITY if PARITY_EN else STOP.
//   PARITY: perr = (XOR(data) ^ bit) != PARITY_ODD -> STOP.
//   STOP: check STOP_BITS bits; any low sets ferr. After the final stop sample (mid-bit) go to DELIVER.
//   The next start edge can therefore be taken half a bit early.
//   DELIVER (1 clk): if ~rx_valid | rx_ready, load rx_data/parity_err/frame_err and set rx_valid=1.
//   Otherwise pulse overrun and keep the old word. Then -> BREAK if ferr & all-zero data & rxs=0,
//   else -> IDLE.
//   BREAK: wait for rxs=1, then -> IDLE. No further words delivered during a held-low line.
// - Handshake: rx_valid stays high and rx_data/flags stay stable until rx_valid & rx_ready.
//   Handshake and DELIVER in the same cycle: the new word loads and rx_valid stays 1.
// - Error flags belong to the word and change only when rx_valid loads.
// - Frames with errors are still delivered; software decides.
// - baud_div=0: tick every clk (fastest legal rate).
// - A baud_div change outside IDLE takes effect at the next frame.
// - Reset mid-frame aborts the frame; the partial word is never delivered.
// TESTING
// - 8N1/16x, baud_div=3, send 0xA5, rx_ready=1 -> rx_valid 1 clk, rx_data=0xA5, no error flags.
// - 8E1 frame 0x07 with wrong parity bit (0) -> rx_data=0x07, parity_err=1, frame_err=0.
// - Stop bit driven low, data 0x3C -> frame_err=1, FSM returns IDLE.
//   Line held low 20 bits (break) -> one word 0x00 with frame_err=1, then BREAK until rx high.
// - 1-tick low glitch on idle line, then 5-tick low pulse -> no rx_valid, busy returns 0,
//   next 0x55 frame received correctly.
// - rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once.
//   Raise rx_ready -> 0x11 accepted, no 0x22.
// - DATA_BITS=7, STOP_BITS=2, OVERSAMPLE=8: send 0x5A with rst pulsed low mid-data,
//   then a clean 0x2B -> outputs 0 after reset, only 0x2B delivered.

Source files
------------

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param_if
//  Description : Valid/ready word port between the UART receiver and the
//                register block. The receiver drives the word and its error
//                flags; the consumer drives rx_ready.
//                  rx_data    : received word, LSB = first bit on the line
//                  rx_valid   : rx_data and flags hold a word
//                  rx_ready   : consumer accepts when rx_valid & rx_ready
//                  parity_err : parity mismatch for the word in rx_data
//                  frame_err  : a stop bit was sampled low for that word
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;

    // Receiver side
    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        input  rx_ready
    );

    // Consumer side
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param
//  Description : Parametrised UART receiver. Configurable data width, parity,
//                stop bits and oversampling; runtime baud divisor. Start, data,
//                parity and stop bits use a 2-of-3 majority of three mid-bit
//                samples. Parity, framing and overrun errors are reported and
//                words are handed over on a valid/ready interface.
//  Ports       :
//      clk_i      in   system clock
//      rst_ni     in   asynchronous active-low reset
//      baud_div_i in   clocks per oversample tick minus 1 (sampled in IDLE)
//      rx_i       in   asynchronous serial input, idle high
//      rx_bus     ---  word port (master modport): rx_data, rx_valid,
//                      rx_ready, parity_err, frame_err
//      overrun_o  out  1-clk pulse: frame finished while the previous word
//                      was still pending; the new frame is dropped
//      busy_o     out  high while a frame is being received
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic [DIV_W-1:0] baud_div_i,
    input  wire logic             rx_i,
    uart_rx_param_if.master       rx_bus,
    output logic                  overrun_o,
    output logic                  busy_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int CNT_W = 4;

    // Oversample tick positions of the three mid-bit samples and the bit end
    localparam logic [OS_W-1:0]  C_OS_S0     = OS_W'(OVERSAMPLE/2 - 1);
    localparam logic [OS_W-1:0]  C_OS_S1     = OS_W'(OVERSAMPLE/2);
    localparam logic [OS_W-1:0]  C_OS_S2     = OS_W'(OVERSAMPLE/2 + 1);
    localparam logic [OS_W-1:0]  C_OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] C_LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] C_LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic             C_PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_DELIVER = 3'd5,
        S_BREAK   = 3'd6
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic                   rx_meta_q, rxs_q, rxs_prev_q;
    logic [DIV_W-1:0]       div_cnt_q, baud_q;
    logic [OS_W-1:0]        os_cnt_q;
    logic [2:0]             samp_q;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic w_idle;
    logic w_start_edge;
    logic w_tick;
    logic w_bit_end;
    logic w_mid_last;
    logic w_maj_reg;
    logic w_maj_live;

    assign w_idle       = (state_q == S_IDLE);
    assign w_start_edge = w_idle & rxs_prev_q & ~rxs_q;
    assign w_tick       = ~w_idle & (div_cnt_q == '0);
    assign w_bit_end    = w_tick & (os_cnt_q == C_OS_LAST);
    assign w_mid_last   = w_tick & (os_cnt_q == C_OS_S2);

    // Majority of the three stored samples, valid once the bit has ended
    assign w_maj_reg  = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                        (samp_q[1] & samp_q[2]);
    // Majority on the third-sample tick itself: the third vote is taken
    // straight from the synchroniser so the last stop bit can be judged
    // without waiting for the end of the bit.
    assign w_maj_live = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) |
                        (samp_q[1] & rxs_q);

    // ------------------------------------------------------------------------
    // Input synchroniser, idle-high reset value so reset never looks like a
    // start edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx_i;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // ------------------------------------------------------------------------
    // Baud tick generator and mid-bit sampler. While idle the divider is held
    // at the (freshly latched) divisor so a frame always starts with a full
    // tick period aligned to the start edge, and a divisor change during a
    // frame only applies to the next one.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            baud_q    <= '0;
            os_cnt_q  <= '0;
            samp_q    <= '1;
        end else if (w_idle) begin
            div_cnt_q <= baud_div_i;
            baud_q    <= baud_div_i;
            os_cnt_q  <= '0;
        end else if (w_tick) begin
            div_cnt_q <= baud_q;
            os_cnt_q  <= (os_cnt_q == C_OS_LAST) ? '0 : os_cnt_q + 1'b1;
            if (os_cnt_q == C_OS_S0) samp_q[0] <= rxs_q;
            if (os_cnt_q == C_OS_S1) samp_q[1] <= rxs_q;
            if (os_cnt_q == C_OS_S2) samp_q[2] <= rxs_q;
        end else begin
            div_cnt_q <= div_cnt_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM: state and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        rx_data_d    = rx_data_q;
        // A pending word is released by the handshake; DELIVER may re-set it
        rx_valid_d   = rx_valid_q & ~rx_bus.rx_ready;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (w_start_edge) begin
                    state_d   = S_START;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end

            S_START: begin
                // A start bit that reads high at mid-bit was a glitch
                if (w_bit_end) begin
                    state_d = w_maj_reg ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    shreg_d = {w_maj_reg, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == C_LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    perr_d  = (((^shreg_q) ^ w_maj_reg) != C_PAR_ODD);
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                if (bit_cnt_q == C_LAST_STOP) begin
                    // Leave at mid-bit so the next start edge is not missed
                    if (w_mid_last) begin
                        if (!w_maj_live) ferr_d = 1'b1;
                        state_d = S_DELIVER;
                    end
                end else if (w_bit_end) begin
                    if (!w_maj_reg) ferr_d = 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            S_DELIVER: begin
                if (!rx_valid_q || rx_bus.rx_ready) begin
                    rx_data_d    = shreg_q;
                    parity_err_d = perr_q;
                    frame_err_d  = ferr_q;
                    rx_valid_d   = 1'b1;
                end else begin
                    overrun_d    = 1'b1;
                end
                // All-zero frame with a low stop bit and a line still low is
                // a break: report it once and then wait for the line to idle.
                if (ferr_q && (shreg_q == '0) && !rxs_q) begin
                    state_d = S_BREAK;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_BREAK: begin
                if (rxs_q) state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rx_bus.rx_data    = rx_data_q;
    assign rx_bus.rx_valid   = rx_valid_q;
    assign rx_bus.parity_err = parity_err_q;
    assign rx_bus.frame_err  = frame_err_q;
    assign overrun_o         = overrun_q;
    assign busy_o            = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_param
//  Description : Directed bench for uart_rx_param. Three receivers share the
//                clock: A = 8N1/16x, B = 8E1/16x, C = 7N2/8x. Serial frames
//                are driven bit by bit; words are captured by per-receiver
//                monitors and compared with hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int C_BIT16 = 64;   // 16 ticks x (baud_div+1 = 4) clocks
    localparam int C_BIT8  = 32;   //  8 ticks x 4 clocks

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_c_n;
    logic [15:0] baud_div;
    logic        rx_a, rx_b, rx_c;
    logic        ovr_a, ovr_b, ovr_c;
    logic        busy_a, busy_b, busy_c;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) ifa ();
    uart_rx_param_if #(.DATA_BITS(8)) ifb ();
    uart_rx_param_if #(.DATA_BITS(7)) ifc ();

    uart_rx_param #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1),
                    .OVERSAMPLE(16), .DIV_W(16)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .baud_div_i(baud_div), .rx_i(rx_a),
        .rx_bus(ifa.master), .overrun_o(ovr_a), .busy_o(busy_a));

    uart_rx_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1),
                    .OVERSAMPLE(16), .DIV_W(16)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .baud_div_i(baud_div), .rx_i(rx_b),
        .rx_bus(ifb.master), .overrun_o(ovr_b), .busy_o(busy_b));

    uart_rx_param #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2),
                    .OVERSAMPLE(8), .DIV_W(16)) u_c (
        .clk_i(clk), .rst_ni(rst_c_n), .baud_div_i(baud_div), .rx_i(rx_c),
        .rx_bus(ifc.master), .overrun_o(ovr_c), .busy_o(busy_c));

    // ------------------------------------------------------------------------
    // Monitors: count valid cycles, accepted words and overrun pulses
    // ------------------------------------------------------------------------
    int         vcyc_a = 0, acc_a = 0, acc_b = 0, acc_c = 0;
    int         ovr_cnt_a = 0, ovr_cnt_b = 0, ovr_cnt_c = 0;
    logic [7:0] cap_data_a = '0, cap_data_b = '0;
    logic [6:0] cap_data_c = '0;
    logic [1:0] cap_fl_a = '0, cap_fl_b = '0, cap_fl_c = '0;   // {parity, frame}

    always @(negedge clk) begin
        if (ifa.rx_valid) vcyc_a++;
        if (ifa.rx_valid && ifa.rx_ready) begin
            acc_a++; cap_data_a = ifa.rx_data; cap_fl_a = {ifa.parity_err, ifa.frame_err};
        end
        if (ifb.rx_valid && ifb.rx_ready) begin
            acc_b++; cap_data_b = ifb.rx_data; cap_fl_b = {ifb.parity_err, ifb.frame_err};
        end
        if (ifc.rx_valid && ifc.rx_ready) begin
            acc_c++; cap_data_c = ifc.rx_data; cap_fl_c = {ifc.parity_err, ifc.frame_err};
        end
        if (ovr_a) ovr_cnt_a++;
        if (ovr_b) ovr_cnt_b++;
        if (ovr_c) ovr_cnt_c++;
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance n clocks; inputs change 1 time unit after the rising edge
    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Move to a sampling point well away from the rising edge
    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_rx(input int which, input logic v);
        case (which)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par, input int nstop,
                              input logic stopv, input int bitclk);
        set_rx(which, 1'b0);
        tick_n(bitclk);
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, data[i]);
            tick_n(bitclk);
        end
        if (has_par) begin
            set_rx(which, par);
            tick_n(bitclk);
        end
        for (int i = 0; i < nstop; i++) begin
            set_rx(which, stopv);
            tick_n(bitclk);
        end
        set_rx(which, 1'b1);
        tick_n(2 * bitclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int v0, a0, o0;

        rst_n = 1'b1; rst_c_n = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        baud_div = 16'd3;
        ifa.rx_ready = 1'b1; ifb.rx_ready = 1'b1; ifc.rx_ready = 1'b1;
        #2;
        rst_n = 1'b0; rst_c_n = 1'b0;
        tick_n(4);

        // Reset state
        sample();
        chk("rst_a_valid", 32'(ifa.rx_valid), 32'd0);
        chk("rst_a_data",  32'(ifa.rx_data),  32'd0);
        chk("rst_a_misc",  32'({ifa.parity_err, ifa.frame_err, ovr_a, busy_a}), 32'd0);
        chk("rst_b_all",   32'({ifb.rx_valid, ifb.rx_data, ovr_b, busy_b}), 32'd0);
        tick_n(1);
        rst_n = 1'b1; rst_c_n = 1'b1;
        tick_n(10);

        // 8N1 0xA5, ready high: one valid cycle, clean flags
        v0 = vcyc_a; a0 = acc_a;
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, C_BIT16);
        sample();
        chk("a5_valid_cycles", 32'(vcyc_a - v0), 32'd1);
        chk("a5_accepted",     32'(acc_a - a0),  32'd1);
        chk("a5_data",         32'(cap_data_a),  32'h0A5);
        chk("a5_flags",        32'(cap_fl_a),    32'd0);
        chk("a5_busy",         32'(busy_a),      32'd0);

        // 8E1 0x07 (three ones): correct even parity is 1, send 0
        a0 = acc_b;
        send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1, 1'b1, C_BIT16);
        sample();
        chk("par_bad_acc",   32'(acc_b - a0), 32'd1);
        chk("par_bad_data",  32'(cap_data_b), 32'h07);
        chk("par_bad_flags", 32'(cap_fl_b),   32'b10);
        // Same word with the correct parity bit
        send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1, C_BIT16);
        sample();
        chk("par_ok_acc",   32'(acc_b - a0), 32'd2);
        chk("par_ok_flags", 32'(cap_fl_b),   32'b00);

        // Stop bit low, data 0x3C: framing error, back to IDLE
        a0 = acc_a;
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0, C_BIT16);
        sample();
        chk("ferr_acc",   32'(acc_a - a0), 32'd1);
        chk("ferr_data",  32'(cap_data_a), 32'h3C);
        chk("ferr_flags", 32'(cap_fl_a),   32'b01);
        chk("ferr_idle",  32'(busy_a),     32'd0);

        // Break: line low for 20 bit times
        a0 = acc_a;
        set_rx(0, 1'b0);
        tick_n(20 * C_BIT16);
        sample();
        chk("brk_acc",   32'(acc_a - a0), 32'd1);
        chk("brk_data",  32'(cap_data_a), 32'h00);
        chk("brk_flags", 32'(cap_fl_a),   32'b01);
        chk("brk_busy",  32'(busy_a),     32'd1);
        tick_n(1);
        set_rx(0, 1'b1);
        tick_n(C_BIT16);
        sample();
        chk("brk_release_busy", 32'(busy_a),     32'd0);
        chk("brk_single_word",  32'(acc_a - a0), 32'd1);

        // Glitch rejection: 1-tick and 5-tick low pulses
        a0 = acc_a;
        tick_n(1);
        set_rx(0, 1'b0); tick_n(4);
        set_rx(0, 1'b1); tick_n(10);
        sample();
        chk("glitch_busy_seen", 32'(busy_a), 32'd1);
        tick_n(190);
        set_rx(0, 1'b0); tick_n(20);
        set_rx(0, 1'b1); tick_n(200);
        sample();
        chk("glitch_no_word", 32'(acc_a - a0), 32'd0);
        chk("glitch_idle",    32'(busy_a),     32'd0);
        tick_n(1);
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1, C_BIT16);
        sample();
        chk("post_glitch_acc",   32'(acc_a - a0), 32'd1);
        chk("post_glitch_data",  32'(cap_data_a), 32'h55);
        chk("post_glitch_flags", 32'(cap_fl_a),   32'd0);

        // Overrun: consumer stalled for two frames
        tick_n(1);
        ifa.rx_ready = 1'b0;
        a0 = acc_a; o0 = ovr_cnt_a;
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, C_BIT16);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, C_BIT16);
        sample();
        chk("ovr_hold_data",  32'(ifa.rx_data),      32'h11);
        chk("ovr_hold_valid", 32'(ifa.rx_valid),     32'd1);
        chk("ovr_pulses",     32'(ovr_cnt_a - o0),   32'd1);
        chk("ovr_none_acc",   32'(acc_a - a0),       32'd0);
        tick_n(1);
        ifa.rx_ready = 1'b1;
        tick_n(3);
        sample();
        chk("ovr_acc_data",  32'(cap_data_a),  32'h11);
        chk("ovr_acc_valid", 32'(ifa.rx_valid), 32'd0);
        tick_n(200);
        sample();
        chk("ovr_no_second", 32'(acc_a - a0), 32'd1);

        // 7N2/8x: reset in the middle of 0x5A, then a clean 0x2B
        tick_n(1);
        a0 = acc_c;
        set_rx(2, 1'b0); tick_n(C_BIT8);          // start
        set_rx(2, 1'b0); tick_n(C_BIT8);          // bit0 of 0x5A
        set_rx(2, 1'b1); tick_n(C_BIT8);          // bit1
        set_rx(2, 1'b0); tick_n(C_BIT8 / 2);      // half of bit2
        sample();
        chk("c_busy_mid", 32'(busy_c), 32'd1);
        rst_c_n = 1'b0;
        tick_n(1);
        set_rx(2, 1'b1);
        tick_n(2);
        sample();
        chk("c_rst_outputs",
            32'({ifc.rx_valid, ifc.rx_data, ifc.parity_err, ifc.frame_err, ovr_c, busy_c}),
            32'd0);
        tick_n(2);
        rst_c_n = 1'b1;
        tick_n(3 * C_BIT8);
        send_frame(2, 9'h02B, 7, 1'b0, 1'b0, 2, 1'b1, C_BIT8);
        sample();
        chk("c_acc",   32'(acc_c - a0), 32'd1);
        chk("c_data",  32'(cap_data_c), 32'h2B);
        chk("c_flags", 32'(cap_fl_c),   32'd0);
        chk("c_idle",  32'(busy_c),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
